// File: rtl/tdm_demux4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_pkg : shared slot count, slot index type and FSM states          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tdm_pkg;

  localparam int SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  localparam slot_idx_t LAST_SLOT = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tdm_demux4_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux4_if : serial slot input and assembled frame output bundle  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tdm_demux4_if
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
);

  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_sof;
  logic [SLOTS*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SLOTS-1:0]        lane_strobe;
  logic                    sync_err;
  logic                    overflow;

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  out_data, out_valid, lane_strobe, sync_err, overflow
  );

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output out_data, out_valid, lane_strobe, sync_err, overflow
  );

endinterface
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux4 : 4-slot TDM receiver, assembles slot beats into frames   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  localparam int FRAME_W = SLOTS * DATA_W;

  state_e              state_q, state_d;
  slot_idx_t           count_q, count_d;
  slot_idx_t           wr_slot;
  logic                wr_en;
  logic                complete;
  logic                sync_err_q, sync_err_d;
  logic [FRAME_W-1:0]  stage_q, stage_d;
  logic [FRAME_W-1:0]  out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                overflow_q, overflow_d;
  logic [SLOTS-1:0]    strobe_q, strobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      stage_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      strobe_q    <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stage_q     <= stage_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      strobe_q    <= strobe_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Slot routing; an in_sof restarts the frame and wipes any partial data.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    stage_d    = stage_q;
    wr_en      = 1'b0;
    wr_slot    = '0;
    complete   = 1'b0;
    sync_err_d = 1'b0;
    strobe_d   = '0;
    if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_sof) begin
            wr_en   = 1'b1;
            stage_d = '0;
            count_d = 2'd1;
            state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          wr_en = 1'b1;
          if (bus.in_sof) begin
            sync_err_d = 1'b1;
            stage_d    = '0;
            count_d    = 2'd1;
          end else begin
            wr_slot = count_q;
            count_d = count_q + 2'd1;
            if (count_q == LAST_SLOT) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (wr_en) begin
      stage_d[int'(wr_slot)*DATA_W +: DATA_W] = bus.in_data;
      strobe_d[wr_slot] = 1'b1;
    end
  end

  // A completed frame needs the holding register free, or being drained now.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    if (complete) begin
      if (!out_valid_q || bus.out_ready) begin
        out_data_d  = stage_d;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.lane_strobe = strobe_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: DATA_W, default 1, width of one TDM slot in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_data  input  DATA_W  serial slot payload.
REQ-005 Port: in_valid  input  1  in_data valid this cycle (one beat).
REQ-006 Port: in_sof  input  1  start of frame; qualifies the beat as slot 0 (meaningful only with in_valid).
REQ-007 Port: out_data  output  4*DATA_W  assembled frame; slot i at bits [i*DATA_W +: DATA_W].
REQ-008 Port: out_valid  output  1  out_data holds a complete frame.
REQ-009 Port: out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-010 Port: lane_strobe  output  4  one-hot pulse marking the slot written on the previous cycle.
REQ-011 Port: sync_err  output  1  one-cycle pulse: frame truncated by an early in_sof.
REQ-012 Port: overflow  output  1  sticky flag: completed frame dropped for lack of space.

Function
REQ-013 The block SHALL be the receive end of a 4-slot TDM link: accepted beat k of a frame SHALL be routed to slot k (0..3).
REQ-014 FSM states SHALL be IDLE and COLLECT.
REQ-015 IDLE: in_valid && !in_sof SHALL be discarded with no other effect. in_valid && in_sof SHALL write slot 0, set count=1 and go to COLLECT.
REQ-016 COLLECT: in_valid && !in_sof SHALL write slot count and increment count. The beat written at count==3 SHALL complete the frame, wrap count to 0 and return to IDLE.
REQ-017 COLLECT: in_valid && in_sof SHALL pulse sync_err the next cycle, discard the partial frame, write this beat to slot 0, set count=1 and remain in COLLECT.
REQ-018 Cycles without in_valid SHALL not change count, state or the staging registers.
REQ-019 On completion: out_data SHALL load all 4 slots and out_valid SHALL rise the cycle after the 4th accepted beat (latency 1 cycle).
REQ-020 out_valid and out_data SHALL hold stable until out_valid && out_ready; out_valid SHALL then clear unless a new frame completes in the same cycle.
REQ-021 Completion in the same cycle as out_valid && out_ready SHALL load the new frame and keep out_valid high; no overflow.
REQ-022 Completion while out_valid && !out_ready SHALL drop the new frame, keep the old out_data, and set overflow until reset.
REQ-023 lane_strobe[i] SHALL pulse for exactly 1 cycle, the cycle after a beat is written to slot i; at most one bit SHALL be high at a time; discarded IDLE beats SHALL produce no strobe.
REQ-024 DATA_W SHALL be at least 1; there SHALL be no arithmetic on the payload.

Reset
REQ-025 rst SHALL act immediately (asynchronous), independent of clk.
REQ-026 During reset: state IDLE, count 0, staging registers 0, out_data 0, out_valid 0, lane_strobe 0, sync_err 0, overflow 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first beat after release SHALL require in_sof.

Structure
REQ-028 Package tdm_pkg SHALL hold SLOTS=4, the slot-index typedef (2 bits) and the FSM state enum.
REQ-029 Single module; no sub-module is required.

Verification
REQ-030 DATA_W=1; beats 0,1,0,1 with in_sof on the first, out_ready=1 -> out_data=4'b1010, out_valid high 1 cycle, one cycle after the 4th beat.
REQ-031 Beats 1,1 then in_sof with beats 0,0,0,0 -> sync_err pulse after the 3rd beat; out_data=4'b0000; no frame from the truncated data.
REQ-032 out_ready=0, two complete frames A then B -> out_data stays A, overflow=1; then out_ready=1 -> A consumed, out_valid=0.
REQ-033 Frame completes in the same cycle as out_valid && out_ready -> new data loaded, out_valid stays 1, overflow=0.
REQ-034 Beats without in_sof in IDLE -> no lane_strobe, no out_valid. Assert rst after 2 beats of a frame -> all outputs 0; the next frame decodes correctly.
REQ-035 200 random frames with random in_valid gaps and random out_ready -> every accepted out_data equals the sent slots[3:0]; lane_strobe order is 0,1,2,3 per frame.
